dmem_responder: RTL and testbench

Data-memory responder that serves load/store requests issued by the MEM pipeline stage. It samples the stage's address, store data and direction strobes, runs a fixed-latency access against an internal word-addressed RAM, and returns load data with a one-cycle acknowledge. The MEM stage holds its request stable until that acknowledge arrives. This block is the memory-side endpoint of the CPU data bus.

---
 rtl/dmem_responder.sv | 114 +++++++++++
 tb/tb_dmem_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side endpoint of the CPU data bus.
// Accepts one load/store from the MEM stage, waits READ_LAT+1 cycles in WAIT,
// commits against an internal word-addressed RAM, then pulses DACK for one
// cycle. Misaligned requests skip the RAM and answer with DACK and DERR.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int READ_LAT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        TRANDATADDR,
  input  logic        SORL,
  input  logic [31:0] DADDR,
  input  logic [31:0] DATAO,
  output logic [31:0] MEMDATAI,
  output logic        DACK,
  output logic        DSTALL,
  output logic        DERR,
  output logic [1:0]  state_dbg
);

  // Handshake: TRANDATADDR is the request valid and is held, with SORL, DADDR
  // and DATAO, until DACK. DACK is the one-cycle completion; the request is
  // consumed on the rising edge where DACK=1, and DSTALL (= TRANDATADDR & ~DACK)
  // holds the pipeline on every other cycle of a pending request. Request
  // fields are captured only on the IDLE acceptance edge.

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic                  op_store;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] widx;
  logic [31:0]           wdata;
  logic                  commit;
  logic                  unused_addr;

  logic [31:0] ram [0:(1<<ADDR_WIDTH)-1];

  // Upper address bits are deliberately dropped so addresses alias.
  assign unused_addr = ^DADDR[31:ADDR_WIDTH+2];

  // The access takes effect on the last WAIT edge.
  assign commit = (state == WAIT) && (cnt == 4'd0);

  // Request capture, wait countdown and response sequencing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      op_store <= 1'b0;
      err_q    <= 1'b0;
      widx     <= '0;
      wdata    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (TRANDATADDR) begin
            if (DADDR[1:0] == 2'b00) begin
              op_store <= SORL;
              widx     <= DADDR[ADDR_WIDTH+1:2];
              wdata    <= DATAO;
              cnt      <= 4'(READ_LAT);
              err_q    <= 1'b0;
              state    <= WAIT;
            end else begin
              err_q    <= 1'b1;
              state    <= RESP;
            end
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // RAM write port; contents are never reset. A reset before the commit edge
  // forces state to IDLE, so an aborted store never writes.
  always_ff @(posedge clk) begin
    if (commit && op_store) begin
      ram[widx] <= wdata;
    end
  end

  // Load data register: updates only on a completed aligned load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      MEMDATAI <= 32'd0;
    end else if (commit && !op_store) begin
      MEMDATAI <= ram[widx];
    end
  end

  assign DACK      = (state == RESP);
  assign DERR      = DACK & err_q;
  assign DSTALL    = TRANDATADDR & ~DACK;
  assign state_dbg = state;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: self-checking bench for dmem_responder.
// Two instances share one stimulus: READ_LAT=2 (default) and READ_LAT=0.
// sel picks which instance is observed.
module tb_dmem_responder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        trandataddr;
  logic        sorl;
  logic [31:0] daddr;
  logic [31:0] datao;

  logic [31:0] memdatai_2, memdatai_0;
  logic        dack_2, dack_0, dstall_2, dstall_0, derr_2, derr_0;
  logic [1:0]  state_2, state_0;

  logic        sel;
  logic [31:0] memdatai_m;
  logic        dack_m, dstall_m, derr_m;
  logic [1:0]  state_m;

  dmem_responder #(.ADDR_WIDTH(10), .READ_LAT(2)) dut (
    .clk(clk), .reset(rst_n), .TRANDATADDR(trandataddr), .SORL(sorl),
    .DADDR(daddr), .DATAO(datao), .MEMDATAI(memdatai_2), .DACK(dack_2),
    .DSTALL(dstall_2), .DERR(derr_2), .state_dbg(state_2)
  );

  dmem_responder #(.ADDR_WIDTH(10), .READ_LAT(0)) dut0 (
    .clk(clk), .reset(rst_n), .TRANDATADDR(trandataddr), .SORL(sorl),
    .DADDR(daddr), .DATAO(datao), .MEMDATAI(memdatai_0), .DACK(dack_0),
    .DSTALL(dstall_0), .DERR(derr_0), .state_dbg(state_0)
  );

  assign memdatai_m = sel ? memdatai_0 : memdatai_2;
  assign dack_m     = sel ? dack_0     : dack_2;
  assign dstall_m   = sel ? dstall_0   : dstall_2;
  assign derr_m     = sel ? derr_0     : derr_2;
  assign state_m    = sel ? state_0    : state_2;

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  int          cur_lat;
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  logic [31:0] model [0:1023];
  logic [31:0] last_load;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait for DACK, compare against the queue heads, then drop the request.
  task automatic finish_access(input int start_cyc, input int exp_cyc);
    int   cyc;
    logic got;
    cyc = start_cyc;
    got = 1'b0;
    while (!got && cyc < 50) begin
      @(negedge clk);
      if (dack_m) begin
        got = 1'b1;
      end else begin
        check("dstall_busy", 32'(dstall_m), 32'd1);
        cyc++;
      end
    end
    check("dack_seen", 32'(got), 32'd1);
    if (got) begin
      check("dack_cycle", cyc, exp_cyc);
      check("dstall_ack", 32'(dstall_m), 32'd0);
      check("memdatai", memdatai_m, exp_q.pop_front());
      check("derr", 32'(derr_m), 32'(exp_err_q.pop_front()));
    end else begin
      void'(exp_q.pop_front());
      void'(exp_err_q.pop_front());
    end
    @(posedge clk); #1;
    trandataddr = 1'b0;
    @(negedge clk);
    check("dack_pulse", 32'(dack_m), 32'd0);
    check("idle_after", 32'(state_m), 32'd0);
  endtask

  // ---------------- driver ----------------
  task automatic access(input logic st, input logic [31:0] addr, input logic [31:0] data);
    logic       aligned;
    logic [9:0] idx;
    aligned = (addr[1:0] == 2'b00);
    idx     = addr[11:2];
    if (!aligned) begin
      exp_q.push_back(last_load);
      exp_err_q.push_back(1'b1);
    end else if (st) begin
      model[idx] = data;
      exp_q.push_back(last_load);
      exp_err_q.push_back(1'b0);
    end else begin
      last_load = model[idx];
      exp_q.push_back(model[idx]);
      exp_err_q.push_back(1'b0);
    end
    @(posedge clk); #1;
    trandataddr = 1'b1;
    sorl        = st;
    daddr       = addr;
    datao       = data;
    finish_access(0, aligned ? cur_lat + 2 : 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          cyc;
    logic        got;
    logic [9:0]  idxs [8];
    logic [31:0] a;

    sel         = 1'b0;
    cur_lat     = 2;
    last_load   = 32'd0;
    rst_n       = 1'b0;
    trandataddr = 1'b1;
    sorl        = 1'b1;
    daddr       = 32'h0000_0040;
    datao       = 32'hA5A5_A5A5;

    // Reset held with a pending request: outputs quiet, DSTALL follows request.
    repeat (3) @(negedge clk);
    check("rst_memdatai", memdatai_m, 32'd0);
    check("rst_dack", 32'(dack_m), 32'd0);
    check("rst_derr", 32'(derr_m), 32'd0);
    check("rst_state", 32'(state_m), 32'd0);
    check("rst_dstall", 32'(dstall_m), 32'd1);

    // Release: the held store is accepted on the first rising edge.
    model[10'h010] = 32'hA5A5_A5A5;
    exp_q.push_back(32'd0);
    exp_err_q.push_back(1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("accept_first_edge", 32'(state_m), 32'd1);
    finish_access(2, 4);

    // Store then load.
    access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    access(1'b0, 32'h0000_0010, 32'h0);

    // Aliasing modulo RAM size.
    access(1'b1, 32'h0000_1004, 32'h1234_5678);
    access(1'b0, 32'h0000_0004, 32'h0);

    // Misaligned load and store: error, no RAM effect, MEMDATAI held.
    access(1'b0, 32'h0000_0013, 32'h0);
    access(1'b1, 32'h0000_0011, 32'h5555_5555);
    access(1'b0, 32'h0000_0010, 32'h0);
    access(1'b0, 32'h0000_0040, 32'h0);

    // Random aligned stores (with random aliasing bits), read back in reverse.
    for (int i = 0; i < 8; i++) begin
      idxs[i] = 10'($urandom_range(64, 127));
      a = {18'd0, 2'($urandom_range(0, 3)), idxs[i], 2'b00};
      access(1'b1, a, $urandom);
    end
    for (int i = 7; i >= 0; i--) begin
      access(1'b0, {20'd0, idxs[i], 2'b00}, 32'h0);
    end

    // Mid-access reset aborts a store before its commit edge.
    access(1'b1, 32'h0000_0020, 32'h1111_1111);
    @(posedge clk); #1;
    trandataddr = 1'b1;
    sorl        = 1'b1;
    daddr       = 32'h0000_0020;
    datao       = 32'hCAFE_F00D;
    @(negedge clk);
    @(negedge clk);
    check("abort_in_wait", 32'(state_m), 32'd1);
    rst_n       = 1'b0;
    trandataddr = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_state", 32'(state_m), 32'd0);
    check("abort_memdatai", memdatai_m, 32'd0);
    check("abort_dack", 32'(dack_m), 32'd0);
    rst_n     = 1'b1;
    last_load = 32'd0;
    access(1'b0, 32'h0000_0020, 32'h0);

    // Back-to-back loads on the READ_LAT=0 instance.
    repeat (4) @(negedge clk);
    sel     = 1'b1;
    cur_lat = 0;
    access(1'b1, 32'h0000_0000, 32'h0BAD_F00D);
    access(1'b1, 32'h0000_0004, 32'h1357_9BDF);
    access(1'b1, 32'h0000_0008, 32'h2468_ACE0);
    for (int k = 0; k < 3; k++) exp_q.push_back(model[k]);
    @(posedge clk); #1;
    trandataddr = 1'b1;
    sorl        = 1'b0;
    daddr       = 32'h0000_0000;
    cyc         = 0;
    for (int k = 0; k < 3; k++) begin
      got = 1'b0;
      while (!got && cyc < 60) begin
        @(negedge clk);
        if (dack_m) got = 1'b1;
        else cyc++;
      end
      check("b2b_seen", 32'(got), 32'd1);
      check("b2b_cycle", cyc, 2 + 3 * k);
      check("b2b_data", memdatai_m, exp_q.pop_front());
      cyc++;
      @(posedge clk); #1;
      if (k < 2) daddr = 32'((k + 1) * 4);
      else trandataddr = 1'b0;
    end
    @(negedge clk);
    check("b2b_idle", 32'(state_m), 32'd0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
